// File: rtl/imem_fetch_port_pkg.sv
// Shared definitions for the handshaked instruction memory.
// Holds the FSM encoding, latency limits and default widths.
package imem_fetch_port_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } fetch_state_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 10;

endpackage

// File: rtl/imem_fetch_port_if.sv
// Fetch request/response channel between the fetch stage and the memory.
// The master issues byte-addressed requests; the slave returns instructions.
interface imem_fetch_port_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH+1:0] req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_instr;
    logic                  rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_err
    );
endinterface

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one enabled read port.
// A read and write of the same word at one edge returns the old contents.
module imem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter     INIT_FILE  = "code.mem"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Read register only moves on i_re, so it holds across later writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rdata <= '0;
        else if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/imem_fetch_port.sv
// Handshaked instruction fetch port with programmable response latency.
// Flags misaligned fetches and counts completed response handshakes.
module imem_fetch_port
    import imem_fetch_port_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LATENCY    = 1,
    parameter     INIT_FILE  = "code.mem"
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_fetch_port_if.slave      bus,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [31:0]           fetch_count
);
    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("imem_fetch_port: LATENCY out of range 1..15");
    end

    localparam logic [3:0] CNT_LOAD = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    fetch_state_t          r_state;
    fetch_state_t          w_next;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic                  r_mis;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [31:0]           r_fetch_count;

    logic                  w_accept;
    logic                  w_hs;
    logic                  w_sample;
    logic                  w_mis;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign bus.req_ready = (r_state == IDLE) && !reset;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_hs          = r_rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_next = (LATENCY == 1) ? RESP : WAIT;
            WAIT: if (r_cnt == 4'd0) w_next = RESP;
            RESP: if (w_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // With LATENCY==1 the array is read straight from the request bus.
    always_comb begin
        w_sample = 1'b0;
        w_mis    = r_mis;
        w_raddr  = r_waddr;
        unique case (r_state)
            IDLE: begin
                w_sample = w_accept && (LATENCY == 1);
                w_mis    = |bus.req_addr[1:0];
                w_raddr  = bus.req_addr[ADDR_WIDTH+1:2];
            end
            WAIT: w_sample = (r_cnt == 4'd0);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_waddr     <= '0;
            r_mis       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && w_accept) begin
                r_waddr <= bus.req_addr[ADDR_WIDTH+1:2];
                r_mis   <= |bus.req_addr[1:0];
                r_cnt   <= CNT_LOAD;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_sample) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_mis;
            end else if (w_hs) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_fetch_count <= '0;
        else if (w_hs)
            r_fetch_count <= r_fetch_count + 32'd1;
    end

    imem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .rst     (reset),
        .i_we    (wr_en),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_re    (w_sample),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_instr = r_rsp_err ? '0 : w_rdata;
    assign fetch_count   = r_fetch_count;
endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed bench for imem_fetch_port at LATENCY 1, 4 and 3.
// Program words are loaded through the write port before fetching.
module tb_imem_fetch_port;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NI = 3;
    localparam int LAT [NI] = '{1, 4, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req_valid   [NI];
    logic [AW+1:0] req_addr    [NI];
    logic          rsp_ready   [NI];
    logic          wr_en       [NI];
    logic [AW-1:0] wr_addr     [NI];
    logic [DW-1:0] wr_data     [NI];
    logic          req_ready   [NI];
    logic          rsp_valid   [NI];
    logic [DW-1:0] rsp_instr   [NI];
    logic          rsp_err     [NI];
    logic [31:0]   fetch_count [NI];

    for (genvar k = 0; k < NI; k++) begin : g
        imem_fetch_port_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
        logic [31:0] cnt;

        assign bus.req_valid = req_valid[k];
        assign bus.req_addr  = req_addr[k];
        assign bus.rsp_ready = rsp_ready[k];
        assign req_ready[k]  = bus.req_ready;
        assign rsp_valid[k]  = bus.rsp_valid;
        assign rsp_instr[k]  = bus.rsp_instr;
        assign rsp_err[k]    = bus.rsp_err;
        assign fetch_count[k] = cnt;

        imem_fetch_port #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (AW),
            .LATENCY    (LAT[k]),
            .INIT_FILE  ("")
        ) dut (
            .clk         (clk),
            .reset       (rst),
            .bus         (bus),
            .wr_en       (wr_en[k]),
            .wr_addr     (wr_addr[k]),
            .wr_data     (wr_data[k]),
            .fetch_count (cnt)
        );
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the cycle count from the accepting cycle to rsp_valid.
    task automatic fetch(input int k, input logic [AW+1:0] addr,
                         output int lat);
        chk("req_ready_before_fetch", req_ready[k], 1);
        req_valid[k] = 1'b1;
        req_addr[k]  = addr;
        lat = 0;
        do begin
            tick();
            req_valid[k] = 1'b0;
            lat++;
        end while (!rsp_valid[k] && lat < 40);
    endtask

    task automatic handshake(input int k);
        rsp_ready[k] = 1'b1;
        tick();
        rsp_ready[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 1'b0;
            req_addr[k]  = '0;
            rsp_ready[k] = 1'b0;
            wr_en[k]     = 1'b0;
            wr_addr[k]   = '0;
            wr_data[k]   = '0;
        end

        tick();
        tick();
        chk("rst_req_ready", req_ready[0], 0);
        chk("rst_rsp_valid", rsp_valid[0], 0);
        chk("rst_rsp_instr", rsp_instr[1], 0);
        chk("rst_rsp_err", rsp_err[1], 0);
        chk("rst_fetch_count", fetch_count[2], 0);
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", req_ready[0], 1);

        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < NI; k++) begin
                wr_en[k]   = 1'b1;
                wr_addr[k] = AW'(w);
                wr_data[k] = 32'h0010_0001 + 32'(w);
            end
            tick();
        end
        for (int k = 0; k < NI; k++) wr_en[k] = 1'b0;

        // LATENCY 1, aligned fetch of word 2
        fetch(0, 12'h008, lat);
        chk("l1_latency", 64'(lat), 1);
        chk("l1_instr", rsp_instr[0], 32'h0010_0003);
        chk("l1_err", rsp_err[0], 0);
        chk("l1_ready_in_resp", req_ready[0], 0);
        tick();
        chk("l1_ready_held", req_ready[0], 0);
        chk("l1_count_before", fetch_count[0], 0);
        handshake(0);
        chk("l1_valid_after_hs", rsp_valid[0], 0);
        chk("l1_count_after", fetch_count[0], 1);
        chk("l1_ready_after_hs", req_ready[0], 1);

        // LATENCY 4, response held under backpressure
        fetch(1, 12'h00C, lat);
        chk("l4_latency", 64'(lat), 4);
        chk("l4_instr", rsp_instr[1], 32'h0010_0004);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("l4_hold_valid", rsp_valid[1], 1);
            chk("l4_hold_instr", rsp_instr[1], 32'h0010_0004);
            chk("l4_hold_ready", req_ready[1], 0);
            chk("l4_hold_count", fetch_count[1], 0);
        end
        handshake(1);
        chk("l4_count_after", fetch_count[1], 1);

        // Misaligned fetch then aligned fetch
        fetch(1, 12'h006, lat);
        chk("mis_latency", 64'(lat), 4);
        chk("mis_err", rsp_err[1], 1);
        chk("mis_instr", rsp_instr[1], 0);
        handshake(1);
        fetch(1, 12'h004, lat);
        chk("aligned_err", rsp_err[1], 0);
        chk("aligned_instr", rsp_instr[1], 32'h0010_0002);
        handshake(1);
        chk("l4_count_3", fetch_count[1], 3);

        // Write and sample of word 2 on the same edge
        wr_en[0]   = 1'b1;
        wr_addr[0] = 10'd2;
        wr_data[0] = 32'hDEAD_BEEF;
        fetch(0, 12'h008, lat);
        wr_en[0] = 1'b0;
        chk("rbw_instr", rsp_instr[0], 32'h0010_0003);
        wr_en[0]   = 1'b1;
        wr_addr[0] = 10'd1;
        wr_data[0] = 32'h0BAD_F00D;
        tick();
        wr_en[0] = 1'b0;
        chk("resp_write_hold", rsp_instr[0], 32'h0010_0003);
        handshake(0);
        fetch(0, 12'h008, lat);
        chk("after_write_w2", rsp_instr[0], 32'hDEAD_BEEF);
        handshake(0);
        fetch(0, 12'h004, lat);
        chk("after_write_w1", rsp_instr[0], 32'h0BAD_F00D);
        handshake(0);
        chk("l1_count_4", fetch_count[0], 4);

        // Reset while the LATENCY 3 instance sits in WAIT
        req_valid[2] = 1'b1;
        req_addr[2]  = 12'h000;
        tick();
        req_valid[2] = 1'b0;
        tick();
        chk("wait_no_valid", rsp_valid[2], 0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", rsp_valid[2], 0);
        chk("midrst_ready", req_ready[2], 0);
        chk("midrst_count_l1", fetch_count[0], 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rel_ready", req_ready[2], 1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("dropped_valid", rsp_valid[2], 0);
        end
        chk("dropped_count", fetch_count[2], 0);
        fetch(2, 12'h004, lat);
        chk("l3_latency", 64'(lat), 3);
        chk("l3_instr_mem_kept", rsp_instr[2], 32'h0010_0002);
        handshake(2);
        chk("l3_count", fetch_count[2], 1);

        // fetch_count wrap
        force g[0].dut.r_fetch_count = 32'hFFFF_FFFF;
        #2;
        release g[0].dut.r_fetch_count;
        #1;
        chk("preset_count", fetch_count[0], 32'hFFFF_FFFF);
        fetch(0, 12'h000, lat);
        chk("wrap_instr", rsp_instr[0], 32'h0010_0001);
        handshake(0);
        chk("wrap_count", fetch_count[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
